// File: rtl/alu_shift_seq.sv
// Sequential SRL/SLL/SRA unit: one bit of shift per clock behind a
// start/busy/done handshake, result held until the next accepted request.
module alu_shift_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [3:0]         operacion_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   resultado_o
);

  localparam logic [3:0]         OP_SRL   = 4'b0111;
  localparam logic [3:0]         OP_SLL   = 4'b1000;
  localparam logic [3:0]         OP_SRA   = 4'b1001;
  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic [WIDTH-1:0]   sh_r;
  logic [WIDTH-1:0]   sh_nxt_s;
  logic [3:0]         op_r;
  logic [3:0]         op_nxt_s;
  logic [SHAMT_W-1:0] cnt_r;
  logic [SHAMT_W-1:0] cnt_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic               done_r;
  logic               done_nxt_s;

  function automatic logic is_shift_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_SRL:  legal = 1'b1;
      OP_SLL:  legal = 1'b1;
      OP_SRA:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // One-bit step; SRA replicates the sign bit so it survives every step.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic [3:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      sh_r    <= {WIDTH{1'b0}};
      op_r    <= 4'b0000;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sh_r    <= sh_nxt_s;
      op_r    <= op_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic; a request is taken in IDLE and also in DONE (no bubble).
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i && is_shift_op(operacion_i)) begin
          accept_s    = 1'b1;
          state_nxt_s = (shamt_i != CNT_ZERO) ? ST_SHIFT : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start_i && is_shift_op(operacion_i)) begin
          accept_s    = 1'b1;
          state_nxt_s = (shamt_i != CNT_ZERO) ? ST_SHIFT : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath updates and next values of the handshake outputs.
  always_comb begin
    sh_nxt_s   = sh_r;
    op_nxt_s   = op_r;
    cnt_nxt_s  = cnt_r;
    busy_nxt_s = (state_nxt_s == ST_SHIFT);
    done_nxt_s = (state_nxt_s == ST_DONE);
    if (accept_s) begin
      sh_nxt_s  = a_i;
      op_nxt_s  = operacion_i;
      cnt_nxt_s = shamt_i;
    end else if (state_r == ST_SHIFT) begin
      sh_nxt_s  = shift_step(sh_r, op_r);
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      sh_nxt_s  = sh_r;
      cnt_nxt_s = cnt_r;
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign resultado_o = sh_r;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed, table-driven bench for alu_shift_seq with hand-written
// sequences for mid-shift start, back-to-back accept, reset and illegal codes.
module tb_alu_shift_seq;

  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  alu_shift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .operacion_i (op),
    .a_i         (a),
    .shamt_i     (shamt),
    .busy_o      (busy),
    .done_o      (done),
    .resultado_o (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts busy cycles from the current cycle until done_o, bounded.
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      step();
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] av,
                        input logic [4:0] sh, input logic [31:0] exp);
    int nb;
    bit seen;
    start = 1'b1; op = o; a = av; shamt = sh;
    step();
    start = 1'b0; op = 4'b0000; a = 32'h0000_0000; shamt = 5'd0;
    wait_done(nb, seen);
    check({name, " done_seen"}, {31'd0, seen}, 32'd1);
    check({name, " busy_cycles"}, nb, {27'd0, sh});
    check({name, " result"}, res, exp);
    step();
    check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
    check({name, " result_held"}, res, exp);
  endtask

  initial begin
    int nb;
    int nb2;
    bit seen;
    int nbad;

    n_vec = 0;
    n_err = 0;
    vecs[0] = '{OP_SLL, 32'h0000_0001, 5'd4,  32'h0000_0010};
    vecs[1] = '{OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[3] = '{OP_SRA, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[4] = '{OP_SRL, 32'hF0F0_0000, 5'd8,  32'h00F0_F000};
    vecs[5] = '{OP_SRA, 32'h8000_F000, 5'd4,  32'hF800_0F00};
    vecs[6] = '{OP_SLL, 32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A};
    vecs[7] = '{OP_SRA, 32'h7FFF_FFFF, 5'd3,  32'h0FFF_FFFF};
    vecs[8] = '{OP_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[9] = '{OP_SRL, 32'h1234_5678, 5'd16, 32'h0000_1234};

    rst = 1'b1; start = 1'b0; op = 4'b0000; a = 32'h0000_0000; shamt = 5'd0;
    step();
    step();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", res, 32'h0000_0000);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].shamt, vecs[i].exp);
    end

    // shamt=0: done right after accept, never busy.
    start = 1'b1; op = OP_SRA; a = 32'h1234_5678; shamt = 5'd0;
    step();
    start = 1'b0;
    check("sh0 busy", {31'd0, busy}, 32'd0);
    check("sh0 done", {31'd0, done}, 32'd1);
    step();

    // start pulsed mid-shift with different operands is ignored.
    start = 1'b1; op = OP_SRL; a = 32'hF0F0_0000; shamt = 5'd8;
    step();
    start = 1'b0; a = 32'h0000_0000;
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) nb++;
      step();
    end
    if (busy) nb++;
    start = 1'b1; op = OP_SLL; a = 32'hFFFF_FFFF; shamt = 5'd2;
    step();
    start = 1'b0;
    wait_done(nb2, seen);
    check("midstart done_seen", {31'd0, seen}, 32'd1);
    check("midstart busy_cycles", nb + nb2, 32'd8);
    check("midstart result", res, 32'h00F0_F000);

    // Back-to-back accept in the DONE cycle.
    start = 1'b1; op = OP_SLL; a = 32'h0000_0001; shamt = 5'd1;
    step();
    start = 1'b0;
    check("b2b busy", {31'd0, busy}, 32'd1);
    check("b2b done_low", {31'd0, done}, 32'd0);
    step();
    check("b2b done", {31'd0, done}, 32'd1);
    check("b2b result", res, 32'h0000_0002);
    step();

    // Reset mid-shift at cnt=10 of a 20-bit shift drops the operation.
    start = 1'b1; op = OP_SLL; a = 32'h0000_0003; shamt = 5'd20;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("prerst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", res, 32'h0000_0000);
    nbad = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) nbad++;
      step();
    end
    check("midrst no_done_after", nbad, 32'd0);

    // Illegal code: ignored, result held.
    run_op("pre_illegal", OP_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010);
    start = 1'b1; op = OP_ADD; a = 32'hFFFF_FFFF; shamt = 5'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("illegal busy c%0d", i), {31'd0, busy}, 32'd0);
      check($sformatf("illegal done c%0d", i), {31'd0, done}, 32'd0);
      check($sformatf("illegal result c%0d", i), res, 32'h0000_0010);
    end
    start = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
